// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch stage.
//
// The unit holds the fetch PC and runs a request/acknowledge handshake with
// instruction memory. It presents the PC and link value (PC+4) of the
// instruction in decode. It redirects on a jump or a taken branch, and each
// redirect raises a one-cycle flush pulse.
//
// Optional feature macro: PCU_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect target sends fetch to TRAP_VECTOR and
//               pulses PCU_Misalign together with PCU_Flush.
//   undefined : a misaligned target is forced down to word alignment, and
//               there is no PCU_Misalign port.
//
// State machine:
//   BOOT     : one idle cycle after reset, no request.
//   FETCH    : issues requests, captures acknowledged instructions and
//              takes redirects.
//   REDIRECT : one idle cycle while the fetch in flight is discarded.

module pc_fetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic            PCU_CLOCK,
  input  logic            PCU_RESET,
  input  logic            PCU_Jump_En,
  input  logic            PCU_Jump_Reg,
  input  logic            PCU_Branch_Taken,
  input  logic [XLEN-1:0] PCU_Target,
  input  logic            PCU_Stall,
  output logic            PCU_Imem_Req,
  output logic [XLEN-1:0] PCU_Imem_Addr,
  input  logic            PCU_Imem_Ack,
  output logic [XLEN-1:0] PCU_Pc,
  output logic [XLEN-1:0] PCU_Pc_Plus4,
  output logic            PCU_Inst_Valid,
  output logic            PCU_Flush
`ifdef PCU_MISALIGN_TRAP_EN
  ,
  output logic            PCU_Misalign
`endif
);

  // Sequential increment; the addition wraps modulo 2^XLEN.
  localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};
  // Clears bit 0 of a JALR target.
  localparam logic [XLEN-1:0] JALR_MASK  = {{(XLEN-1){1'b1}}, 1'b0};
  // Forces a target down to a word boundary.
  localparam logic [XLEN-1:0] WORD_MASK  = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] RESET_LINK = RESET_VECTOR + PC_STEP;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  // Next sequential address, wrapping at the top of the address space.
  function automatic logic [XLEN-1:0] pc_add4(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

  // A JALR computes its target from a register, so bit 0 is dropped.
  // A JAL or a branch target is used unchanged.
  function automatic logic [XLEN-1:0] jump_target(
    input logic [XLEN-1:0] target,
    input logic            is_jalr
  );
    logic [XLEN-1:0] mask;
    if (is_jalr) begin
      mask = JALR_MASK;
    end else begin
      mask = {XLEN{1'b1}};
    end
    return target & mask;
  endfunction

`ifdef PCU_MISALIGN_TRAP_EN
  // An instruction address must sit on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction
`endif

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic            inst_valid_q, inst_valid_d;
  logic            flush_q, flush_d;
`ifdef PCU_MISALIGN_TRAP_EN
  logic            misalign_q, misalign_d;
  logic            target_misaligned_s;
`else
  logic            unused_trap_vector_s;
`endif

  logic            imem_req_s;
  logic            redirect_s;
  logic [XLEN-1:0] eff_target_s;
  logic [XLEN-1:0] redirect_pc_s;

  // Request only while fetching, and only when downstream can take the result.
  always_comb begin
    imem_req_s = (state_q == ST_FETCH) & ~PCU_Stall;
  end

  // Redirect decode: only a valid, unstalled decode instruction can redirect.
  always_comb begin
    redirect_s   = (state_q == ST_FETCH) & inst_valid_q & ~PCU_Stall &
                   (PCU_Jump_En | PCU_Branch_Taken);
    eff_target_s = jump_target(PCU_Target, PCU_Jump_En & PCU_Jump_Reg);
  end

`ifdef PCU_MISALIGN_TRAP_EN
  // A misaligned target goes to the trap vector instead of being fetched.
  always_comb begin
    target_misaligned_s = is_misaligned(eff_target_s);
    if (target_misaligned_s) begin
      redirect_pc_s = TRAP_VECTOR;
    end else begin
      redirect_pc_s = eff_target_s;
    end
  end
`else
  // Without the trap, a misaligned target is silently word-aligned.
  always_comb begin
    redirect_pc_s        = eff_target_s & WORD_MASK;
    unused_trap_vector_s = ^TRAP_VECTOR;
  end
`endif

  // Next-state logic for the fetch state machine and the decode registers.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pc_d         = pc_q;
    pc_plus4_d   = pc_plus4_q;
    inst_valid_d = inst_valid_q;
    flush_d      = 1'b0;
`ifdef PCU_MISALIGN_TRAP_EN
    misalign_d   = 1'b0;
`endif
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect_s) begin
          // The redirect wins over a same-cycle Ack. That Ack's instruction
          // is dropped and the fetch PC does not step.
          fetch_pc_d   = redirect_pc_s;
          inst_valid_d = 1'b0;
          flush_d      = 1'b1;
`ifdef PCU_MISALIGN_TRAP_EN
          misalign_d   = target_misaligned_s;
`endif
          state_d      = ST_REDIRECT;
        end else if (PCU_Stall) begin
          // Hold the decode instruction and the fetch PC while stalled.
          fetch_pc_d   = fetch_pc_q;
          inst_valid_d = inst_valid_q;
        end else if (imem_req_s & PCU_Imem_Ack) begin
          pc_d         = fetch_pc_q;
          pc_plus4_d   = pc_add4(fetch_pc_q);
          inst_valid_d = 1'b1;
          fetch_pc_d   = pc_add4(fetch_pc_q);
        end else begin
          // No instruction came back, so decode gets a bubble.
          inst_valid_d = 1'b0;
        end
      end
      ST_REDIRECT: begin
        state_d = ST_FETCH;
      end
      default: begin
        state_d      = ST_BOOT;
        inst_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset. Reset drops any pending fetch.
  always_ff @(posedge PCU_CLOCK) begin
    if (PCU_RESET) begin
      state_q      <= ST_BOOT;
      fetch_pc_q   <= RESET_VECTOR;
      pc_q         <= RESET_VECTOR;
      pc_plus4_q   <= RESET_LINK;
      inst_valid_q <= 1'b0;
      flush_q      <= 1'b0;
`ifdef PCU_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pc_q         <= pc_d;
      pc_plus4_q   <= pc_plus4_d;
      inst_valid_q <= inst_valid_d;
      flush_q      <= flush_d;
`ifdef PCU_MISALIGN_TRAP_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  // Drive the outputs. The request is the only combinational output.
  always_comb begin
    PCU_Imem_Req   = imem_req_s;
    PCU_Imem_Addr  = fetch_pc_q;
    PCU_Pc         = pc_q;
    PCU_Pc_Plus4   = pc_plus4_q;
    PCU_Inst_Valid = inst_valid_q;
    PCU_Flush      = flush_q;
`ifdef PCU_MISALIGN_TRAP_EN
    PCU_Misalign   = misalign_q;
`endif
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit. A table of per-cycle vectors is applied in a
// loop. Each vector's expected outputs go into a scoreboard queue when the
// vector is driven. They come back out and are compared when the outputs
// are sampled. A few hand-written sequences cover the boot latency and stall
// corner cases.
// Build with PCU_MISALIGN_TRAP_EN defined to test the misalign-trap variant.

module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        jen;
  logic        jreg;
  logic        bt;
  logic [31:0] tgt;
  logic        stall;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        valid;
  logic        flush;
`ifdef PCU_MISALIGN_TRAP_EN
  logic        mis;
  localparam logic [31:0] MIS_ADDR = 32'h0000_0100;
`else
  localparam logic [31:0] MIS_ADDR = 32'h0000_0040;
`endif

  typedef struct {
    logic        rst;
    logic        stall;
    logic        ack;
    logic        jen;
    logic        jreg;
    logic        bt;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_flush;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  pc_fetch_unit dut (
    .PCU_CLOCK       (clk),
    .PCU_RESET       (rst),
    .PCU_Jump_En     (jen),
    .PCU_Jump_Reg    (jreg),
    .PCU_Branch_Taken(bt),
    .PCU_Target      (tgt),
    .PCU_Stall       (stall),
    .PCU_Imem_Req    (req),
    .PCU_Imem_Addr   (addr),
    .PCU_Imem_Ack    (ack),
    .PCU_Pc          (pc),
    .PCU_Pc_Plus4    (pc4),
    .PCU_Inst_Valid  (valid),
    .PCU_Flush       (flush)
`ifdef PCU_MISALIGN_TRAP_EN
    ,
    .PCU_Misalign    (mis)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t mk(
    input logic r, input logic s, input logic a, input logic je,
    input logic jr, input logic b, input logic [31:0] t,
    input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_pc,
    input logic [31:0] e_pc4, input logic e_v, input logic e_f, input logic e_m
  );
    vec_t v;
    v.rst = r; v.stall = s; v.ack = a; v.jen = je; v.jreg = jr; v.bt = b;
    v.tgt = t; v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc;
    v.e_pc4 = e_pc4; v.e_valid = e_v; v.e_flush = e_f; v.e_mis = e_m;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int waited;
    vec_t e;
    rst = 1'b1; stall = 1'b0; ack = 1'b1; jen = 1'b0; jreg = 1'b0; bt = 1'b0;
    tgt = 32'h0;

    //           rst stl ack jen jrg bt  target        req addr          pc            pc4           v  f  m
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h4,        0, 0, 0)); // reset state, BOOT
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 32'h0,        32'h0,        32'h4,        0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 32'h4,        32'h0,        32'h4,        1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 32'h8,        32'h4,        32'h8,        1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 32'h40,       1, 32'hC,        32'h8,        32'hC,        1, 0, 0)); // JAL 0x40
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        0, 32'h40,       32'h8,        32'hC,        0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 32'h40,       32'h8,        32'hC,        0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 32'h44,       32'h40,       32'h44,       1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 32'h103,      1, 32'h48,       32'h44,       32'h48,       1, 0, 0)); // JALR 0x103
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        0, 32'h100,      32'h44,       32'h48,       0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 32'h100,      32'h44,       32'h48,       0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 32'h10,       1, 32'h104,      32'h100,      32'h104,      1, 0, 0)); // branch 0x10
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        0, 32'h10,       32'h100,      32'h104,      0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 32'h10,       32'h100,      32'h104,      0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 32'h80,     0, 32'h14,       32'h10,       32'h14,       1, 0, 0)); // stalled branch
    end
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 32'h80,       1, 32'h14,       32'h10,       32'h14,       1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        0, 32'h80,       32'h10,       32'h14,       0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 32'h80,       32'h10,       32'h14,       0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 32'h20,       1, 32'h84,       32'h80,       32'h84,       1, 0, 0)); // JAL 0x20
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        0, 32'h20,       32'h80,       32'h84,       0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h20,       32'h80,       32'h84,       0, 0, 0)); // no ack
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h20,       32'h80,       32'h84,       0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 32'h20,       32'h80,       32'h84,       0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h24,       32'h20,       32'h24,       1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 32'h24,       32'h20,       32'h24,       0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 32'h40,       1, 32'h28,       32'h24,       32'h28,       1, 0, 0)); // JAL 0x40
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 32'h0,        0, 32'h40,       32'h24,       32'h28,       0, 1, 0)); // reset in REDIRECT
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h4,        0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 32'h0,        32'h0,        32'h4,        0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 32'hFFFFFFFD, 1, 32'h4,        32'h0,        32'h4,        1, 0, 0)); // JALR to top
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        0, 32'hFFFFFFFC, 32'h0,        32'h4,        0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 32'h0,        32'h4,        0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        1, 32'h0,        32'hFFFFFFFC, 32'h0,        1, 0, 0)); // wrap
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 32'h42,       1, 32'h4,        32'h0,        32'h4,        1, 0, 0)); // misaligned JAL
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        0, MIS_ADDR,     32'h0,        32'h4,        0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,        1, MIS_ADDR,     32'h0,        32'h4,        0, 0, 0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; stall = vecs[i].stall; ack = vecs[i].ack;
      jen = vecs[i].jen; jreg = vecs[i].jreg; bt = vecs[i].bt; tgt = vecs[i].tgt;
      exp_q.push_back(vecs[i]);
      #2;
      e = exp_q.pop_front();
      chk($sformatf("v%0d req", i),   {31'h0, req},   {31'h0, e.e_req});
      chk($sformatf("v%0d addr", i),  addr,           e.e_addr);
      chk($sformatf("v%0d pc", i),    pc,             e.e_pc);
      chk($sformatf("v%0d pc4", i),   pc4,            e.e_pc4);
      chk($sformatf("v%0d valid", i), {31'h0, valid}, {31'h0, e.e_valid});
      chk($sformatf("v%0d flush", i), {31'h0, flush}, {31'h0, e.e_flush});
`ifdef PCU_MISALIGN_TRAP_EN
      chk($sformatf("v%0d misalign", i), {31'h0, mis}, {31'h0, e.e_mis});
`endif
      @(negedge clk);
    end

    // Boot latency: exactly one idle cycle before the first request.
    rst = 1'b1; jen = 1'b0; jreg = 1'b0; bt = 1'b0; stall = 1'b0; ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    waited = 0;
    while (!req && waited < 5) begin
      @(negedge clk);
      #2;
      waited++;
    end
    chk("boot_req_latency", waited, 32'd1);
    chk("boot_first_addr", addr, 32'h0);

    // Stall with no valid instruction: request drops and the fetch PC holds.
    stall = 1'b1;
    #1;
    chk("stall_req_low", {31'h0, req}, 32'h0);
    @(negedge clk);
    #2;
    chk("stall_addr_hold", addr, 32'h0);
    chk("stall_valid_low", {31'h0, valid}, 32'h0);
    stall = 1'b0;
    #1;
    chk("unstall_req_high", {31'h0, req}, 32'h1);
    @(negedge clk);
    #2;
    chk("unstall_valid", {31'h0, valid}, 32'h1);
    chk("unstall_pc", pc, 32'h0);
    chk("unstall_addr", addr, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage, directly downstream of the jump control unit.
- Consumes the jump enable and JALR/JAL distinction from the jump control unit, plus branch-taken and the computed target.
- Holds the fetch PC and drives a request/acknowledge handshake to instruction memory.
- Presents the PC and link value (PC+4) of the instruction in decode; flushes on redirect.

Parameters:
- XLEN, 32, address/PC width.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- TRAP_VECTOR, 32'h0000_0100, misaligned-target trap address (used only with PCU_MISALIGN_TRAP_EN).

Ports:
- PCU_CLOCK  in  1  core clock; all state on rising edge.
- PCU_RESET  in  1  synchronous, active-high reset.
- PCU_Jump_En  in  1  jump in decode (JAL or JALR).
- PCU_Jump_Reg  in  1  1 = JALR (register base), 0 = JAL.
- PCU_Branch_Taken  in  1  conditional branch resolved taken.
- PCU_Target  in  XLEN  jump/branch target from the address adder.
- PCU_Stall  in  1  downstream cannot accept; hold decode instruction.
- PCU_Imem_Req  out  1  fetch request.
- PCU_Imem_Addr  out  XLEN  fetch address.
- PCU_Imem_Ack  in  1  memory accepted request; instruction is on the bus this cycle.
- PCU_Pc  out  XLEN  PC of the instruction in decode.
- PCU_Pc_Plus4  out  XLEN  PCU_Pc+4, link value for rd.
- PCU_Inst_Valid  out  1  decode holds a valid instruction.
- PCU_Flush  out  1  one-cycle pulse; discard the fetch in flight.

Behaviour:
- Reset (PCU_RESET=1 at an edge, any state): state=BOOT, fetch_pc=RESET_VECTOR, PCU_Pc=RESET_VECTOR, PCU_Pc_Plus4=RESET_VECTOR+4, PCU_Inst_Valid=0, PCU_Imem_Req=0, PCU_Flush=0. A pending fetch is abandoned.
- PCU_Imem_Addr = fetch_pc at all times.
- PCU_Imem_Req = (state==FETCH) & ~PCU_Stall.
- Arithmetic: all +4 is modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0.
- redirect = PCU_Inst_Valid & ~PCU_Stall & (PCU_Jump_En | PCU_Branch_Taken).
- eff_target = PCU_Target with bit0 cleared when PCU_Jump_En & PCU_Jump_Reg; otherwise PCU_Target.
- Redirects are ignored while PCU_Stall=1; upstream must hold the inputs until the stall clears.
- BOOT: Req=0 for one cycle, then FETCH.
- FETCH:
  - redirect: fetch_pc<=eff_target, PCU_Inst_Valid<=0, PCU_Flush<=1, go to REDIRECT. Redirect takes priority over a same-cycle Ack; that Ack's instruction is discarded and fetch_pc is not incremented.
  - Req&Ack, no redirect: PCU_Pc<=fetch_pc, PCU_Pc_Plus4<=fetch_pc+4, PCU_Inst_Valid<=1, fetch_pc<=fetch_pc+4. Latency: valid one cycle after the Ack.
  - ~Ack & ~PCU_Stall: PCU_Inst_Valid<=0 (bubble).
  - PCU_Stall=1: PCU_Pc, PCU_Pc_Plus4, PCU_Inst_Valid and fetch_pc all held.
- REDIRECT: Req=0, PCU_Flush<=0, return to FETCH next cycle. Redirect-to-first-request = 2 cycles.
- PCU_Flush is high exactly one cycle per redirect; back-to-back redirects are impossible because Inst_Valid=0 in REDIRECT.
- Misalignment (eff_target[1:0]!=0): behaviour set by the optional feature.

Optional Feature:
- Macro: PCU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output PCU_Misalign (1 bit), reset 0.
  - On a redirect with eff_target[1:0]!=0: fetch_pc<=TRAP_VECTOR and PCU_Misalign pulses high one cycle, aligned with PCU_Flush.
- Undefined: no port; fetch_pc<={eff_target[XLEN-1:2],2'b00}.

Test Plan:
- Reset release, Ack tied 1 -> cycle 1 Req=0; then Addr=0x0,0x4,0x8 on consecutive cycles; Inst_Valid=1 with Pc=0x0, Pc_Plus4=0x4 one cycle after the first Ack.
- JAL at Pc=0x8, Target=0x40 -> Flush one cycle, Inst_Valid=0 for 2 cycles, next request Addr=0x40, Pc=0x40 one cycle after its Ack.
- JALR with Target=0x103 -> with macro: Misalign pulse, next Addr=0x100 (TRAP_VECTOR). Without macro: next Addr=0x100 via bit-clear and align; no Misalign port.
- Stall held 3 cycles while Pc=0x10 valid, Branch_Taken=1, Target=0x80 -> Req=0, Pc=0x10 held, no Flush; redirect to 0x80 on the first unstalled cycle.
- Ack deasserted 2 cycles at Addr=0x20 -> Req stays 1, Addr stays 0x20, Inst_Valid=0 bubbles, then resumes at 0x24.
- RESET asserted mid-REDIRECT with fetch_pc=0x40 -> next cycle state BOOT, Addr=0x0, Flush=0, Inst_Valid=0; fetch_pc=0xFFFFFFFC with Ack -> next Addr=0x0.
